// File: rtl/tlb_op_sequencer_pkg.sv
// Shared definitions for the TLB op sequencer: op codes, FSM states, packed-entry layout.
// The packed entry is {VPN2, ASID, Mask, G, PFN0, C0, D0, V0, PFN1, C1, D1, V1}, 90 bits.
package tlb_op_sequencer_pkg;

    localparam int TLB_ENTRY_W = 90;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'b00,
        OP_TLBR  = 2'b01,
        OP_TLBWI = 2'b10,
        OP_TLBWR = 2'b11
    } tlb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_e;

    localparam int VPN2_W   = 19;
    localparam int ASID_W   = 8;
    localparam int MASK_W   = 12;
    localparam int PFN_W    = 20;
    localparam int CATTR_W  = 3;

    localparam int VPN2_LSB = 71;
    localparam int ASID_LSB = 63;
    localparam int MASK_LSB = 51;
    localparam int G_BIT    = 50;
    localparam int PFN0_LSB = 30;
    localparam int C0_LSB   = 27;
    localparam int D0_BIT   = 26;
    localparam int V0_BIT   = 25;
    localparam int PFN1_LSB = 5;
    localparam int C1_LSB   = 2;
    localparam int D1_BIT   = 1;
    localparam int V1_BIT   = 0;

    function automatic logic op_is_write(input tlb_op_e op);
        return (op == OP_TLBWI) || (op == OP_TLBWR);
    endfunction

endpackage

// File: rtl/tlb_op_sequencer_entry_pack.sv
// Purpose: combinational CP0 EntryHi/EntryLo0/EntryLo1/PageMask -> packed TLB entry.
// Latency: 0 cycles. Backpressure: none (pure combinational).
module tlb_entry_pack
    import tlb_op_sequencer_pkg::*;
(
    input  logic [31:0]            entryhi,
    input  logic [31:0]            entrylo0,
    input  logic [31:0]            entrylo1,
    input  logic [31:0]            pagemask,
    output logic [TLB_ENTRY_W-1:0] entry
);

    always_comb begin
        entry = '0;
        entry[VPN2_LSB +: VPN2_W]  = entryhi[31:13];
        entry[ASID_LSB +: ASID_W]  = entryhi[7:0];
        entry[MASK_LSB +: MASK_W]  = pagemask[24:13];
        // A TLB entry is global only if both halves are marked global.
        entry[G_BIT]               = entrylo0[0] & entrylo1[0];
        entry[PFN0_LSB +: PFN_W]   = entrylo0[25:6];
        entry[C0_LSB +: CATTR_W]   = entrylo0[5:3];
        entry[D0_BIT]              = entrylo0[2];
        entry[V0_BIT]              = entrylo0[1];
        entry[PFN1_LSB +: PFN_W]   = entrylo1[25:6];
        entry[C1_LSB +: CATTR_W]   = entrylo1[5:3];
        entry[D1_BIT]              = entrylo1[2];
        entry[V1_BIT]              = entrylo1[1];
    end

    logic unused_bits;
    assign unused_bits = ^{entryhi[12:8], entrylo0[31:26], entrylo1[31:26],
                           pagemask[31:25], pagemask[12:0]};

endmodule

// File: rtl/tlb_op_sequencer.sv
// Purpose: sequence TLBP/TLBR/TLBWI/TLBWR between CP0 and the TLB array (refetch pulse under TLBOP_REFETCH_EN).
// Latency: accept to done_o 2 cycles for writes, 3 cycles for probe/read.
// Backpressure: req_ready only in IDLE; stall_o holds the pipeline from accept until DONE.
module tlb_op_sequencer
    import tlb_op_sequencer_pkg::*;
#(
    parameter int NUM_ENTRIES = 32,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [1:0]             req_op,
    input  logic [31:0]            req_pc,
    output logic                   req_ready,
    input  logic                   flush,
    output logic                   stall_o,
    input  logic [4:0]             index_i,
    input  logic [31:0]            random_i,
    input  logic [31:0]            entryhi_i,
    input  logic [31:0]            entrylo0_i,
    input  logic [31:0]            entrylo1_i,
    input  logic [31:0]            pagemask_i,
    output logic [IDX_W-1:0]       tlb_idx_o,
    output logic                   tlb_re_o,
    output logic                   tlb_we_o,
    output logic [TLB_ENTRY_W-1:0] tlb_wdata_o,
    input  logic [TLB_ENTRY_W-1:0] tlb_rdata_i,
    output logic                   probe_req_o,
    output logic [18:0]            probe_vpn2_o,
    output logic [7:0]             probe_asid_o,
    input  logic                   probe_hit_i,
    input  logic [IDX_W-1:0]       probe_idx_i,
    output logic                   write_all_o,
    output logic [TLB_ENTRY_W-1:0] cp0_entry_o,
    output logic                   w_index_o,
    output logic                   found_o,
    output logic [4:0]             index_lo5_o,
    output logic                   done_o,
    output logic                   refetch_o,
    output logic [31:0]            refetch_pc_o
);

    seq_state_e             state;
    tlb_op_e                op_q;
    logic                   accept;
    logic [TLB_ENTRY_W-1:0] wr_entry;

    tlb_entry_pack u_pack (
        .entryhi  (entryhi_i),
        .entrylo0 (entrylo0_i),
        .entrylo1 (entrylo1_i),
        .pagemask (pagemask_i),
        .entry    (wr_entry)
    );

    assign accept    = (state == ST_IDLE) && req_valid && !flush;
    assign req_ready = (state == ST_IDLE);
    assign stall_o   = (state != ST_IDLE) || accept;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            op_q         <= OP_TLBP;
            tlb_idx_o    <= '0;
            tlb_re_o     <= 1'b0;
            tlb_we_o     <= 1'b0;
            tlb_wdata_o  <= '0;
            probe_req_o  <= 1'b0;
            probe_vpn2_o <= '0;
            probe_asid_o <= '0;
            write_all_o  <= 1'b0;
            cp0_entry_o  <= '0;
            w_index_o    <= 1'b0;
            found_o      <= 1'b0;
            index_lo5_o  <= '0;
            done_o       <= 1'b0;
        end else begin
            tlb_re_o    <= 1'b0;
            tlb_we_o    <= 1'b0;
            probe_req_o <= 1'b0;
            write_all_o <= 1'b0;
            w_index_o   <= 1'b0;
            done_o      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state        <= ST_ISSUE;
                        op_q         <= tlb_op_e'(req_op);
                        probe_vpn2_o <= entryhi_i[31:13];
                        probe_asid_o <= entryhi_i[7:0];
                        // Strobes are registered here so they are high for exactly the ISSUE cycle.
                        case (tlb_op_e'(req_op))
                            OP_TLBP: begin
                                probe_req_o <= 1'b1;
                                tlb_idx_o   <= '0;
                            end
                            OP_TLBR: begin
                                tlb_re_o  <= 1'b1;
                                tlb_idx_o <= index_i[IDX_W-1:0];
                            end
                            OP_TLBWI: begin
                                tlb_we_o    <= 1'b1;
                                tlb_idx_o   <= index_i[IDX_W-1:0];
                                tlb_wdata_o <= wr_entry;
                            end
                            default: begin
                                tlb_we_o    <= 1'b1;
                                tlb_idx_o   <= random_i[IDX_W-1:0];
                                tlb_wdata_o <= wr_entry;
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    tlb_wdata_o <= '0;
                    if (op_is_write(op_q)) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    state  <= ST_DONE;
                    done_o <= 1'b1;
                    if (op_q == OP_TLBP) begin
                        w_index_o   <= 1'b1;
                        found_o     <= probe_hit_i;
                        index_lo5_o <= probe_hit_i ? 5'(probe_idx_i) : 5'd0;
                    end else begin
                        write_all_o <= 1'b1;
                        cp0_entry_o <= tlb_rdata_i;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TLBOP_REFETCH_EN
    logic [31:0] pc_q;

    // Refetch fires alongside done_o for ops that can change translations seen by fetch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q         <= '0;
            refetch_o    <= 1'b0;
            refetch_pc_o <= '0;
        end else begin
            refetch_o <= 1'b0;
            if (accept) begin
                pc_q <= req_pc;
            end
            if ((state == ST_ISSUE && op_is_write(op_q)) ||
                (state == ST_CAPTURE && op_q == OP_TLBR)) begin
                refetch_o    <= 1'b1;
                refetch_pc_o <= pc_q + 32'd4;
            end
        end
    end
`else
    assign refetch_o    = 1'b0;
    assign refetch_pc_o = '0;

    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

    logic unused_rand;
    assign unused_rand = ^random_i[31:IDX_W];

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Directed bench for tlb_op_sequencer: writes, probes, reads, flush, mid-op reset, refetch.
module tb_tlb_op_sequencer;
    import tlb_op_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_pc;
    logic        req_ready;
    logic        flush;
    logic        stall_o;
    logic [4:0]  index_i;
    logic [31:0] random_i, entryhi_i, entrylo0_i, entrylo1_i, pagemask_i;
    logic [4:0]  tlb_idx_o;
    logic        tlb_re_o, tlb_we_o;
    logic [89:0] tlb_wdata_o, tlb_rdata_i, cp0_entry_o;
    logic        probe_req_o;
    logic [18:0] probe_vpn2_o;
    logic [7:0]  probe_asid_o;
    logic        probe_hit_i;
    logic [4:0]  probe_idx_i;
    logic        write_all_o, w_index_o, found_o, done_o, refetch_o;
    logic [4:0]  index_lo5_o;
    logic [31:0] refetch_pc_o;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tlb_op_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_pc(req_pc), .req_ready(req_ready),
        .flush(flush), .stall_o(stall_o),
        .index_i(index_i), .random_i(random_i), .entryhi_i(entryhi_i),
        .entrylo0_i(entrylo0_i), .entrylo1_i(entrylo1_i), .pagemask_i(pagemask_i),
        .tlb_idx_o(tlb_idx_o), .tlb_re_o(tlb_re_o), .tlb_we_o(tlb_we_o),
        .tlb_wdata_o(tlb_wdata_o), .tlb_rdata_i(tlb_rdata_i),
        .probe_req_o(probe_req_o), .probe_vpn2_o(probe_vpn2_o), .probe_asid_o(probe_asid_o),
        .probe_hit_i(probe_hit_i), .probe_idx_i(probe_idx_i),
        .write_all_o(write_all_o), .cp0_entry_o(cp0_entry_o),
        .w_index_o(w_index_o), .found_o(found_o), .index_lo5_o(index_lo5_o),
        .done_o(done_o), .refetch_o(refetch_o), .refetch_pc_o(refetch_pc_o)
    );

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [89:0] pack_m(input logic [31:0] hi, lo0, lo1, pm);
        return {hi[31:13], hi[7:0], pm[24:13], lo0[0] & lo1[0], lo0[25:1], lo1[25:1]};
    endfunction

    task automatic set_words(input logic [31:0] hi, lo0, lo1, pm);
        entryhi_i  = hi;
        entrylo0_i = lo0;
        entrylo1_i = lo1;
        pagemask_i = pm;
    endtask

    // Presents a request for one cycle (cycle 0), then scrambles the CP0 inputs so
    // anything not latched at accept shows up. Returns at the cycle-1 sample point.
    task automatic start(input logic [1:0] op, input logic [31:0] pc);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_pc    = pc;
        @(negedge clk);
        chk("c0_stall", stall_o, 1'b1);
        chk("c0_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_pc    = ~pc;
        index_i   = ~index_i;
        random_i  = ~random_i;
        set_words(~entryhi_i, ~entrylo0_i, ~entrylo1_i, ~pagemask_i);
        @(negedge clk);
    endtask

    task automatic probe_op(input logic hit, input logic [4:0] idx, input logic [4:0] exp_idx);
        probe_hit_i = ~hit;
        probe_idx_i = 5'd31;
        set_words(32'h0040_2005, 32'h0, 32'h0, 32'h0);
        start(2'b00, 32'h0000_2000);
        chk("p_req", probe_req_o, 1'b1);
        chk("p_vpn2", probe_vpn2_o, 19'h00201);
        chk("p_asid", probe_asid_o, 8'h05);
        chk("p_we", tlb_we_o, 1'b0);
        @(posedge clk); #1;
        probe_hit_i = hit;
        probe_idx_i = idx;
        @(negedge clk);
        chk("p_c2_req", probe_req_o, 1'b0);
        chk("p_c2_done", done_o, 1'b0);
        @(posedge clk); #1;
        probe_hit_i = ~hit;
        probe_idx_i = 5'd31;
        @(negedge clk);
        chk("p_done", done_o, 1'b1);
        chk("p_windex", w_index_o, 1'b1);
        chk("p_found", found_o, hit);
        chk("p_idx", index_lo5_o, exp_idx);
        chk("p_wall", write_all_o, 1'b0);
        chk("p_refetch", refetch_o, 1'b0);
        @(negedge clk);
        chk("p_after_windex", w_index_o, 1'b0);
    endtask

    initial begin
        logic [89:0] exp_w;
        logic [31:0] lo0r;

        rst = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_pc = '0; flush = 1'b0;
        index_i = '0; random_i = '0; set_words('0, '0, '0, '0);
        tlb_rdata_i = '1; probe_hit_i = 1'b0; probe_idx_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_strobes", {tlb_we_o, tlb_re_o, probe_req_o}, 3'b000);
        chk("rst_pulses", {done_o, write_all_o, w_index_o, refetch_o}, 4'b0000);
        chk("rst_found_idx", {found_o, index_lo5_o}, 6'd0);
        chk("rst_wdata", tlb_wdata_o, 90'd0);
        chk("rst_entry", cp0_entry_o, 90'd0);
        chk("rst_tlbidx", tlb_idx_o, 5'd0);
        chk("rst_refetch_pc", refetch_pc_o, 32'd0);

        // TLBWI at index 7, mixed global bits
        index_i = 5'd7; random_i = 32'h0000_0002;
        set_words(32'h0040_2005, 32'h0048_D1DF, 32'h02AF_3C5E, 32'h01FF_E000);
        exp_w = pack_m(32'h0040_2005, 32'h0048_D1DF, 32'h02AF_3C5E, 32'h01FF_E000);
        start(2'b10, 32'h0000_1000);
        chk("wi_we", tlb_we_o, 1'b1);
        chk("wi_re_probe", {tlb_re_o, probe_req_o}, 2'b00);
        chk("wi_idx", tlb_idx_o, 5'd7);
        chk("wi_wdata", tlb_wdata_o, exp_w);
        chk("wi_vpn2", tlb_wdata_o[89:71], 19'h00201);
        chk("wi_asid", tlb_wdata_o[70:63], 8'h05);
        chk("wi_g", tlb_wdata_o[50], 1'b0);
        chk("wi_c1_stall", stall_o, 1'b1);
        @(negedge clk);
        chk("wi_done", done_o, 1'b1);
        chk("wi_c2_we", tlb_we_o, 1'b0);
        chk("wi_c2_stall", stall_o, 1'b1);
        chk("wi_c2_pulses", {write_all_o, w_index_o}, 2'b00);
        @(negedge clk);
        chk("wi_c3_done", done_o, 1'b0);
        chk("wi_c3_stall", stall_o, 1'b0);
        chk("wi_c3_ready", req_ready, 1'b1);

        // TLBWR, index from Random
        index_i = 5'd7; random_i = 32'h0000_013D;
        set_words(32'hFFFF_E0FF, 32'h0000_0007, 32'h03FF_FFFF, 32'h0);
        exp_w = pack_m(32'hFFFF_E0FF, 32'h0000_0007, 32'h03FF_FFFF, 32'h0);
        start(2'b11, 32'h0000_1100);
        chk("wr_we", tlb_we_o, 1'b1);
        chk("wr_idx", tlb_idx_o, 5'd29);
        chk("wr_wdata", tlb_wdata_o, exp_w);
        chk("wr_g", tlb_wdata_o[50], 1'b1);
        @(negedge clk);
        chk("wr_done", done_o, 1'b1);
`ifdef TLBOP_REFETCH_EN
        chk("wr_refetch", refetch_o, 1'b1);
        chk("wr_refetch_pc", refetch_pc_o, 32'h0000_1104);
`else
        chk("wr_refetch", refetch_o, 1'b0);
`endif
        @(negedge clk);

        probe_op(1'b1, 5'd12, 5'd12);
        probe_op(1'b0, 5'd9, 5'd0);

        // TLBR at index 3, array returns PFN0=0xABCDE
        lo0r = {6'd0, 20'hABCDE, 3'd2, 1'b1, 1'b1, 1'b0};
        exp_w = pack_m(32'h1234_6042, lo0r, 32'h0001_0043, 32'h0000_6000);
        index_i = 5'd3; random_i = 32'h0000_0011;
        start(2'b01, 32'h0000_1234);
        chk("rd_re", tlb_re_o, 1'b1);
        chk("rd_we", tlb_we_o, 1'b0);
        chk("rd_idx", tlb_idx_o, 5'd3);
        @(posedge clk); #1;
        tlb_rdata_i = exp_w;
        @(negedge clk);
        chk("rd_c2_re", tlb_re_o, 1'b0);
        chk("rd_c2_wall", write_all_o, 1'b0);
        @(posedge clk); #1;
        tlb_rdata_i = '1;
        @(negedge clk);
        chk("rd_wall", write_all_o, 1'b1);
        chk("rd_done", done_o, 1'b1);
        chk("rd_windex", w_index_o, 1'b0);
        chk("rd_entry", cp0_entry_o, exp_w);
        chk("rd_pfn0", cp0_entry_o[49:30], 20'hABCDE);
`ifdef TLBOP_REFETCH_EN
        chk("rd_refetch", refetch_o, 1'b1);
        chk("rd_refetch_pc", refetch_pc_o, 32'h0000_1238);
`else
        chk("rd_refetch", refetch_o, 1'b0);
`endif
        @(negedge clk);

        // flush in IDLE blocks acceptance
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'b10; flush = 1'b1;
        @(negedge clk);
        chk("fl_stall", stall_o, 1'b0);
        chk("fl_ready", req_ready, 1'b1);
        @(negedge clk);
        chk("fl_no_we", tlb_we_o, 1'b0);
        chk("fl_still_idle", req_ready, 1'b1);
        @(negedge clk);
        chk("fl_no_done", done_o, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;

        // flush during CAPTURE does not cancel a committed TLBR
        index_i = 5'd4;
        start(2'b01, 32'h0000_3000);
        chk("flc_re", tlb_re_o, 1'b1);
        @(posedge clk); #1;
        flush = 1'b1; tlb_rdata_i = 90'h155;
        @(negedge clk);
        chk("flc_c2_stall", stall_o, 1'b1);
        @(posedge clk); #1;
        tlb_rdata_i = '1;
        @(negedge clk);
        chk("flc_wall", write_all_o, 1'b1);
        chk("flc_done", done_o, 1'b1);
        chk("flc_entry", cp0_entry_o, 90'h155);
        @(posedge clk); #1;
        flush = 1'b0;

        // synchronous reset during ISSUE abandons the op
        index_i = 5'd6;
        start(2'b10, 32'h0000_4000);
        chk("rs_we", tlb_we_o, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("rs_done", done_o, 1'b0);
        chk("rs_we_off", tlb_we_o, 1'b0);
        chk("rs_ready", req_ready, 1'b1);
        chk("rs_stall", stall_o, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_done2", done_o, 1'b0);

        // refetch target wraps through a page boundary
        index_i = 5'd1;
        start(2'b10, 32'h8000_1FFC);
        @(negedge clk);
        chk("rf_done", done_o, 1'b1);
`ifdef TLBOP_REFETCH_EN
        chk("rf_pulse", refetch_o, 1'b1);
        chk("rf_pc", refetch_pc_o, 32'h8000_2000);
        @(negedge clk);
        chk("rf_pulse_end", refetch_o, 1'b0);
`else
        chk("rf_pulse", refetch_o, 1'b0);
        chk("rf_pc", refetch_pc_o, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
